decode_stage: RTL and testbench

- Pipeline stage directly downstream of instruction fetch.
- Consumes fetch_data_t (pc, instruction) through a valid/ready register slice and decodes a MIPS subset.
- Reads the register file, resolves BEQ/J and returns branch_judge/jump_judge/branch_address/jump_address to fetch.
- Inserts a one-cycle load-use bubble and emits decode_data_t to execute.

---
 rtl/decode_stage_pkg.sv | 47 ++++
 rtl/decode_stage_decoder.sv | 109 ++++++++++
 rtl/decode_stage.sv | 126 ++++++++++++
 tb/tb_decode_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared encodings and pipeline bundle types for the decode stage.

package common;
    // Primary opcode field values, instr[31:26]
    localparam logic [5:0] F6_SPECIAL = 6'h00;
    localparam logic [5:0] F6_J       = 6'h02;
    localparam logic [5:0] F6_BEQ     = 6'h04;
    localparam logic [5:0] F6_ADDIU   = 6'h09;
    localparam logic [5:0] F6_ORI     = 6'h0D;
    localparam logic [5:0] F6_LUI     = 6'h0F;
    localparam logic [5:0] F6_LW      = 6'h23;
    localparam logic [5:0] F6_SW      = 6'h2B;

    // Function field values for SPECIAL, instr[5:0]
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
endpackage

package pipes;
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
    } fetch_data_t;

    typedef enum logic [3:0] {
        OP_NOP, OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_SLT,
        OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J
    } op_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        op_t         op;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm_ext;
        logic [4:0]  wdst;
        logic        wen;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
    } decode_data_t;
endpackage

// File: rtl/decode_stage_decoder.sv
// Pure combinational instruction decoder for the supported MIPS subset.

module decode_stage_decoder
    import common::*;
    import pipes::*;
(
    input  logic [31:0] i_instr,
    output op_t         o_op,
    output logic [31:0] o_imm_ext,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_wdst,
    output logic        o_wen,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_illegal,
    output logic        o_reads_rt
);
    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [4:0]  w_rd;
    logic [15:0] w_imm;
    logic        w_wen_raw;

    assign w_opcode = i_instr[31:26];
    assign w_funct  = i_instr[5:0];
    assign w_rd     = i_instr[15:11];
    assign w_imm    = i_instr[15:0];
    assign o_rs     = i_instr[25:21];
    assign o_rt     = i_instr[20:16];

    // Register $0 is never a real destination, so it never counts as a write.
    assign o_wen = w_wen_raw & (o_wdst != 5'd0);

    // Classify the instruction and derive immediate, destination and memory flags.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        o_op        = OP_NOP;
        o_imm_ext   = {{16{w_imm[15]}}, w_imm};
        o_wdst      = 5'd0;
        w_wen_raw   = 1'b0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        o_illegal   = 1'b0;
        o_reads_rt  = 1'b0;

        case (w_opcode)
            F6_SPECIAL: begin
                o_reads_rt = 1'b1;
                o_wdst     = w_rd;
                w_wen_raw  = 1'b1;
                case (w_funct)
                    FN_ADDU: o_op = OP_ADDU;
                    FN_SUBU: o_op = OP_SUBU;
                    FN_AND:  o_op = OP_AND;
                    FN_OR:   o_op = OP_OR;
                    FN_XOR:  o_op = OP_XOR;
                    FN_SLT:  o_op = OP_SLT;
                    default: begin
                        o_op       = OP_NOP;
                        o_illegal  = 1'b1;
                        o_reads_rt = 1'b0;
                        o_wdst     = 5'd0;
                        w_wen_raw  = 1'b0;
                    end
                endcase
            end
            F6_ADDIU: begin
                o_op      = OP_ADDIU;
                o_wdst    = o_rt;
                w_wen_raw = 1'b1;
            end
            F6_ORI: begin
                o_op      = OP_ORI;
                o_imm_ext = {16'h0000, w_imm};
                o_wdst    = o_rt;
                w_wen_raw = 1'b1;
            end
            F6_LUI: begin
                o_op      = OP_LUI;
                o_imm_ext = {w_imm, 16'h0000};
                o_wdst    = o_rt;
                w_wen_raw = 1'b1;
            end
            F6_LW: begin
                o_op       = OP_LW;
                o_mem_read = 1'b1;
                o_wdst     = o_rt;
                w_wen_raw  = 1'b1;
            end
            F6_SW: begin
                o_op        = OP_SW;
                o_mem_write = 1'b1;
                o_reads_rt  = 1'b1;
            end
            F6_BEQ: begin
                o_op       = OP_BEQ;
                o_reads_rt = 1'b1;
            end
            F6_J: begin
                o_op = OP_J;
            end
            default: begin
                o_op      = OP_NOP;
                o_illegal = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// Decode stage: valid/ready slice from fetch, register-file read, BEQ/J
// resolution back to fetch and a one-cycle load-use bubble toward execute.

module decode_stage
    import common::*;
    import pipes::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter bit          LOAD_USE_STALL = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  fetch_data_t  fetch_data,
    input  logic         flush,
    output logic [4:0]   rf_ra1,
    output logic [4:0]   rf_ra2,
    input  logic [31:0]  rf_rd1,
    input  logic [31:0]  rf_rd2,
    output logic         branch_judge,
    output logic         jump_judge,
    output logic [31:0]  branch_address,
    output logic [31:0]  jump_address,
    output logic         out_valid,
    input  logic         out_ready,
    output decode_data_t decode_data
);
    logic        r_slice_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_last_load_valid;
    logic [4:0]  r_last_load_dst;

    op_t         w_op;
    logic [31:0] w_imm_ext;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_wdst;
    logic        w_wen;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_illegal;
    logic        w_reads_rt;
    logic        w_hazard;
    logic        w_fire;
    logic [31:0] w_pc_plus4;

    decode_stage_decoder u_decoder (
        .i_instr     (r_instr),
        .o_op        (w_op),
        .o_imm_ext   (w_imm_ext),
        .o_rs        (w_rs),
        .o_rt        (w_rt),
        .o_wdst      (w_wdst),
        .o_wen       (w_wen),
        .o_mem_read  (w_mem_read),
        .o_mem_write (w_mem_write),
        .o_illegal   (w_illegal),
        .o_reads_rt  (w_reads_rt)
    );

    assign rf_ra1 = w_rs;
    assign rf_ra2 = w_rt;

    // A held instruction that sources the register the previous LW is still loading must wait one cycle.
    assign w_hazard = LOAD_USE_STALL && r_slice_valid && r_last_load_valid &&
                      ((w_rs == r_last_load_dst) || (w_reads_rt && (w_rt == r_last_load_dst)));

    assign out_valid = r_slice_valid & ~w_hazard & ~flush;
    assign w_fire    = out_valid & out_ready;
    assign in_ready  = (~r_slice_valid | w_fire) & ~flush;

    // Control transfers resolve only in the cycle the instruction actually issues.
    assign branch_judge = w_fire && (w_op == OP_BEQ) && (rf_rd1 == rf_rd2);
    assign jump_judge   = w_fire && (w_op == OP_J);

    // Targets wrap modulo 2^32 naturally through the 32-bit adder.
    assign w_pc_plus4     = r_pc + 32'd4;
    assign branch_address = w_pc_plus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign jump_address   = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};

    assign decode_data = '{
        pc:          r_pc,
        instruction: r_instr,
        op:          w_op,
        rs_data:     rf_rd1,
        rt_data:     rf_rd2,
        imm_ext:     w_imm_ext,
        wdst:        w_wdst,
        wen:         w_wen,
        mem_read:    w_mem_read,
        mem_write:   w_mem_write,
        illegal:     w_illegal
    };

    // Slice register and load-use history; reset dominates flush, flush dominates normal flow.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            r_slice_valid     <= 1'b0;
            r_pc              <= RESET_PC;
            r_instr           <= 32'h0000_0000;
            r_last_load_valid <= 1'b0;
            r_last_load_dst   <= 5'd0;
        end else if (flush) begin
            r_slice_valid     <= 1'b0;
            r_last_load_valid <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                r_slice_valid <= 1'b1;
                r_pc          <= fetch_data.pc;
                r_instr       <= fetch_data.instruction;
            end else if (w_fire) begin
                r_slice_valid <= 1'b0;
            end

            if (w_fire) begin
                r_last_load_valid <= (w_op == OP_LW) && w_wen;
                r_last_load_dst   <= w_wdst;
            end else if (w_hazard) begin
                r_last_load_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a stalling instance (a) and a
// non-stalling instance (b), scoreboard queues of expected decode bundles.

module tb_decode_stage;
    import pipes::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic         in_valid_a, in_ready_a, flush_a, out_valid_a, out_ready_a, bj_a, jj_a;
    fetch_data_t  fd_a;
    logic [4:0]   ra1_a, ra2_a;
    logic [31:0]  rd1_a, rd2_a, ba_a, ja_a;
    decode_data_t dd_a;

    logic         in_valid_b, in_ready_b, flush_b, out_valid_b, out_ready_b, bj_b, jj_b;
    fetch_data_t  fd_b;
    logic [4:0]   ra1_b, ra2_b;
    logic [31:0]  rd1_b, rd2_b, ba_b, ja_b;
    decode_data_t dd_b;

    logic [31:0] regs [32];
    assign rd1_a = regs[ra1_a];
    assign rd2_a = regs[ra2_a];
    assign rd1_b = regs[ra1_b];
    assign rd2_b = regs[ra2_b];

    decode_stage #(.RESET_PC(32'h0), .LOAD_USE_STALL(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .fetch_data(fd_a), .flush(flush_a), .rf_ra1(ra1_a), .rf_ra2(ra2_a),
        .rf_rd1(rd1_a), .rf_rd2(rd2_a), .branch_judge(bj_a), .jump_judge(jj_a),
        .branch_address(ba_a), .jump_address(ja_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .decode_data(dd_a)
    );

    decode_stage #(.RESET_PC(32'h0), .LOAD_USE_STALL(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .fetch_data(fd_b), .flush(flush_b), .rf_ra1(ra1_b), .rf_ra2(ra2_b),
        .rf_rd1(rd1_b), .rf_rd2(rd2_b), .branch_judge(bj_b), .jump_judge(jj_b),
        .branch_address(ba_b), .jump_address(ja_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .decode_data(dd_b)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    decode_data_t exp_q_a[$];
    decode_data_t exp_q_b[$];
    int fire_cyc_a[$];
    int fire_cyc_b[$];
    decode_data_t e_a, e_b;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every issued bundle is compared against the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid_a === 1'b1 && out_ready_a === 1'b1) begin
            fire_cyc_a.push_back(cyc);
            total_cnt++;
            if (exp_q_a.size() == 0) begin
                $display("FAIL out_a_unexpected got pc=%h instr=%h", dd_a.pc, dd_a.instruction);
            end else begin
                e_a = exp_q_a.pop_front();
                if (dd_a !== e_a)
                    $display("FAIL out_a_bundle pc=%h got=%h want=%h", e_a.pc, dd_a, e_a);
                else
                    pass_cnt++;
            end
        end
        if (reset === 1'b1 && out_valid_b === 1'b1 && out_ready_b === 1'b1) begin
            fire_cyc_b.push_back(cyc);
            total_cnt++;
            if (exp_q_b.size() == 0) begin
                $display("FAIL out_b_unexpected got pc=%h instr=%h", dd_b.pc, dd_b.instruction);
            end else begin
                e_b = exp_q_b.pop_front();
                if (dd_b !== e_b)
                    $display("FAIL out_b_bundle pc=%h got=%h want=%h", e_b.pc, dd_b, e_b);
                else
                    pass_cnt++;
            end
        end
    end

    function automatic decode_data_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                        input op_t op, input logic [31:0] imm,
                                        input logic [4:0] wdst, input logic wen,
                                        input logic mr, input logic mw, input logic ill);
        decode_data_t d;
        d.pc          = pc;
        d.instruction = instr;
        d.op          = op;
        d.rs_data     = regs[instr[25:21]];
        d.rt_data     = regs[instr[20:16]];
        d.imm_ext     = imm;
        d.wdst        = wdst;
        d.wen         = wen;
        d.mem_read    = mr;
        d.mem_write   = mw;
        d.illegal     = ill;
        return d;
    endfunction

    // Present one instruction and hold it until accepted; returns just after the accepting edge.
    task automatic push(input bit sel, input logic [31:0] pc, input logic [31:0] instr,
                        input decode_data_t e, input bit track);
        bit acc = 1'b0;
        if (!sel) begin
            in_valid_a = 1'b1;
            fd_a = '{instruction: instr, pc: pc};
        end else begin
            in_valid_b = 1'b1;
            fd_b = '{instruction: instr, pc: pc};
        end
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = sel ? in_ready_b : in_ready_a;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            total_cnt++;
            $display("FAIL accept_timeout pc=%h got in_ready=0 want 1", pc);
        end else if (track) begin
            if (!sel) exp_q_a.push_back(e);
            else      exp_q_b.push_back(e);
        end
        if (!sel) in_valid_a = 1'b0;
        else      in_valid_b = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && (exp_q_a.size() != 0 || exp_q_b.size() != 0); i++)
            @(posedge clk);
        #1;
        total_cnt++;
        if (exp_q_a.size() != 0 || exp_q_b.size() != 0)
            $display("FAIL drain_timeout pending a=%0d b=%0d want 0", exp_q_a.size(), exp_q_b.size());
        else
            pass_cnt++;
    endtask

    task automatic wait_fire_a();
        bit fired = 1'b0;
        for (int i = 0; i < 20 && !fired; i++) begin
            @(negedge clk);
            fired = out_valid_a && out_ready_a;
        end
        if (!fired) begin
            total_cnt++;
            $display("FAIL fire_timeout got out_valid=%b want 1", out_valid_a);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (out_valid_a !== 1'b0) $display("FAIL reset_held_out_valid got=%b want=0", out_valid_a);
        else pass_cnt++;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0)
            $display("FAIL reset_out_valid got a=%b b=%b want 0", out_valid_a, out_valid_b);
        else pass_cnt++;
        total_cnt++;
        if (in_ready_a !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready_a);
        else pass_cnt++;
        total_cnt++;
        if (bj_a !== 1'b0 || jj_a !== 1'b0)
            $display("FAIL reset_judges got bj=%b jj=%b want 0", bj_a, jj_a);
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_addiu();
        decode_data_t e = mk(32'h0, 32'h2401_0005, OP_ADDIU, 32'd5, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 32'h0, 32'h2401_0005, e, 1'b1);
        @(negedge clk);
        total_cnt++;
        if (out_valid_a !== 1'b1 || dd_a.op !== OP_ADDIU || dd_a.imm_ext !== 32'd5)
            $display("FAIL addiu_latency got valid=%b op=%0d imm=%h want 1/%0d/5",
                     out_valid_a, dd_a.op, dd_a.imm_ext, OP_ADDIU);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_back_to_back();
        fire_cyc_a.delete();
        push(1'b0, 32'h0, 32'h3404_00F0, mk(32'h0, 32'h3404_00F0, OP_ORI, 32'h0000_00F0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
        push(1'b0, 32'h4, 32'h0081_2821, mk(32'h4, 32'h0081_2821, OP_ADDU, 32'h0000_2821, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
        push(1'b0, 32'h8, 32'h00A4_3026, mk(32'h8, 32'h00A4_3026, OP_XOR, 32'h0000_3026, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
        drain();
        total_cnt++;
        if (fire_cyc_a.size() != 3 || fire_cyc_a[2] - fire_cyc_a[0] != 2)
            $display("FAIL b2b_throughput got fires=%0d span=%0d want 3/2", fire_cyc_a.size(),
                     fire_cyc_a.size() == 3 ? fire_cyc_a[2] - fire_cyc_a[0] : -1);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        // Dependent ADDU after LW: exactly one bubble.
        fire_cyc_a.delete();
        push(1'b0, 32'h20, 32'h8C02_0000, mk(32'h20, 32'h8C02_0000, OP_LW, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1);
        push(1'b0, 32'h24, 32'h0041_1821, mk(32'h24, 32'h0041_1821, OP_ADDU, 32'h0000_1821, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
        drain();
        total_cnt++;
        if (fire_cyc_a.size() != 2 || fire_cyc_a[1] - fire_cyc_a[0] != 2)
            $display("FAIL load_use_bubble got fires=%0d gap=%0d want 2/2", fire_cyc_a.size(),
                     fire_cyc_a.size() == 2 ? fire_cyc_a[1] - fire_cyc_a[0] : -1);
        else pass_cnt++;

        // ADDIU writes rt=$2 but does not read it: no bubble.
        fire_cyc_a.delete();
        push(1'b0, 32'h30, 32'h8C02_0000, mk(32'h30, 32'h8C02_0000, OP_LW, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1);
        push(1'b0, 32'h34, 32'h2402_0001, mk(32'h34, 32'h2402_0001, OP_ADDIU, 32'h1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
        drain();
        total_cnt++;
        if (fire_cyc_a.size() != 2 || fire_cyc_a[1] - fire_cyc_a[0] != 1)
            $display("FAIL load_no_rt_read got fires=%0d gap=%0d want 2/1", fire_cyc_a.size(),
                     fire_cyc_a.size() == 2 ? fire_cyc_a[1] - fire_cyc_a[0] : -1);
        else pass_cnt++;

        // Non-stalling instance: dependent pair issues back to back.
        fire_cyc_b.delete();
        push(1'b1, 32'h20, 32'h8C02_0000, mk(32'h20, 32'h8C02_0000, OP_LW, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1);
        push(1'b1, 32'h24, 32'h0041_1821, mk(32'h24, 32'h0041_1821, OP_ADDU, 32'h0000_1821, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
        drain();
        total_cnt++;
        if (fire_cyc_b.size() != 2 || fire_cyc_b[1] - fire_cyc_b[0] != 1)
            $display("FAIL nostall_gap got fires=%0d gap=%0d want 2/1", fire_cyc_b.size(),
                     fire_cyc_b.size() == 2 ? fire_cyc_b[1] - fire_cyc_b[0] : -1);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        regs[1] = 32'd7;
        regs[2] = 32'd8;
        push(1'b0, 32'h10, 32'h1021_0003, mk(32'h10, 32'h1021_0003, OP_BEQ, 32'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        wait_fire_a();
        total_cnt++;
        if (bj_a !== 1'b1 || ba_a !== 32'h20 || jj_a !== 1'b0)
            $display("FAIL beq_taken got bj=%b addr=%h jj=%b want 1/00000020/0", bj_a, ba_a, jj_a);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bj_a !== 1'b0) $display("FAIL beq_pulse got bj=%b want 0", bj_a);
        else pass_cnt++;
        @(posedge clk);
        #1;
        push(1'b0, 32'h10, 32'h1022_0003, mk(32'h10, 32'h1022_0003, OP_BEQ, 32'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        wait_fire_a();
        total_cnt++;
        if (bj_a !== 1'b0 || ba_a !== 32'h20)
            $display("FAIL beq_not_taken got bj=%b addr=%h want 0/00000020", bj_a, ba_a);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_jump();
        push(1'b0, 32'hF000_0000, 32'h0810_0000, mk(32'hF000_0000, 32'h0810_0000, OP_J, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        wait_fire_a();
        total_cnt++;
        if (jj_a !== 1'b1 || ja_a !== 32'hF040_0000 || bj_a !== 1'b0)
            $display("FAIL j_issue got jj=%b addr=%h bj=%b want 1/f0400000/0", jj_a, ja_a, bj_a);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (jj_a !== 1'b0) $display("FAIL j_pulse got jj=%b want 0", jj_a);
        else pass_cnt++;
        @(posedge clk);
        #1;
        push(1'b0, 32'hFFFF_FFFC, 32'h1000_0000, mk(32'hFFFF_FFFC, 32'h1000_0000, OP_BEQ, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        wait_fire_a();
        total_cnt++;
        if (bj_a !== 1'b1 || ba_a !== 32'h0)
            $display("FAIL beq_wrap got bj=%b addr=%h want 1/00000000", bj_a, ba_a);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_stall_flush();
        decode_data_t e = mk(32'h40, 32'h2401_0005, OP_ADDIU, 32'd5, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        out_ready_a = 1'b0;
        push(1'b0, 32'h40, 32'h2401_0005, e, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if (out_valid_a !== 1'b1 || in_ready_a !== 1'b0 || dd_a !== e)
                $display("FAIL stall_hold cyc=%0d got valid=%b rdy=%b pc=%h want 1/0/00000040",
                         i, out_valid_a, in_ready_a, dd_a.pc);
            else pass_cnt++;
        end
        @(posedge clk);
        #1 flush_a = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (out_valid_a !== 1'b0 || in_ready_a !== 1'b0 || bj_a !== 1'b0)
            $display("FAIL flush_cycle got valid=%b rdy=%b bj=%b want 0/0/0", out_valid_a, in_ready_a, bj_a);
        else pass_cnt++;
        @(posedge clk);
        #1;
        flush_a = 1'b0;
        out_ready_a = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1)
            $display("FAIL flush_after got valid=%b rdy=%b want 0/1", out_valid_a, in_ready_a);
        else pass_cnt++;
        @(posedge clk);
        #1;
        push(1'b0, 32'h50, 32'hFC00_0000, mk(32'h50, 32'hFC00_0000, OP_NOP, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
        wait_fire_a();
        total_cnt++;
        if (dd_a.illegal !== 1'b1 || dd_a.wen !== 1'b0)
            $display("FAIL illegal_op got ill=%b wen=%b want 1/0", dd_a.illegal, dd_a.wen);
        else pass_cnt++;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++)
            regs[i] = (i == 0) ? 32'h0 : 32'h0000_1000 + 32'(i);
        in_valid_a = 1'b0; flush_a = 1'b0; out_ready_a = 1'b1; fd_a = '0;
        in_valid_b = 1'b0; flush_b = 1'b0; out_ready_b = 1'b1; fd_b = '0;

        test_reset();
        test_addiu();
        test_back_to_back();
        test_load_use();
        test_branch();
        test_jump();
        test_stall_flush();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
